// File: rtl/fetch_align_pkg.sv
// Shared types for the fetch alignment stage: FSM states, halfword width,
// and the RVC length check.
package fetch_align_pkg;

    localparam int HW_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } fetch_state_e;

    function automatic logic is_rvc(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Three-entry halfword queue with 0/1/2 push and pop in the same cycle.
module fetch_hw_queue
    import fetch_align_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        push_cnt,
    input  logic [2*HW_W-1:0] push_data,
    input  logic [1:0]        pop_cnt,
    output logic [1:0]        count,
    output logic [HW_W-1:0]   head,
    output logic [HW_W-1:0]   next_hw
);

    logic [HW_W-1:0] q  [3];
    logic [HW_W-1:0] nq [3];
    logic [1:0]      rem;
    logic [1:0]      count_nxt;

    always_comb begin
        rem   = count - pop_cnt;
        nq[0] = q[0];
        nq[1] = q[1];
        nq[2] = q[2];
        case (pop_cnt)
            2'd1: begin
                nq[0] = q[1];
                nq[1] = q[2];
            end
            2'd2: nq[0] = q[2];
            default: ;
        endcase
        // Pushed halfwords land right behind the survivors of the pop.
        for (int i = 0; i < 3; i++) begin
            if (push_cnt != 2'd0 && 3'(i) == {1'b0, rem})
                nq[i] = push_data[HW_W-1:0];
            if (push_cnt == 2'd2 && 3'(i) == {1'b0, rem} + 3'd1)
                nq[i] = push_data[2*HW_W-1:HW_W];
        end
        count_nxt = rem + push_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < 3; i++)
                q[i] <= nq[i];
        end
    end

    assign head    = q[0];
    assign next_hw = q[1];

endmodule

// File: rtl/fetch_align.sv
// Fetch stage: one outstanding word fetch, realigns 16/32-bit RISC-V
// instructions from a halfword queue toward decode.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        is_compressed,
    output logic        inst_valid,
    input  logic        inst_ready
);

    fetch_state_e    state;
    logic            skip_low;
    logic [1:0]      count;
    logic [1:0]      pop_cnt;
    logic [1:0]      push_cnt;
    logic [1:0]      count_after_pop;
    logic [HW_W-1:0] head;
    logic [HW_W-1:0] next_hw;
    logic [31:0]     push_data;
    logic            xfer;
    logic            rsp_ok;

    assign is_compressed = is_rvc(head);
    assign inst_valid    = (count != 2'd0 && is_compressed) || count >= 2'd2;
    assign inst          = is_compressed ? {16'h0, head} : {next_hw, head};

    assign xfer    = inst_valid && inst_ready && !redirect && !rst;
    assign pop_cnt = !xfer ? 2'd0 : (is_compressed ? 2'd1 : 2'd2);

    // Only ask for a word when a full one is guaranteed to fit.
    assign count_after_pop = count - pop_cnt;
    assign mem_req = state == IDLE && count_after_pop <= 2'd1
                     && !redirect && !rst;

    assign rsp_ok    = state == WAIT && mem_rvalid && !redirect && !rst;
    assign push_cnt  = !rsp_ok ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
    assign push_data = skip_low ? {16'h0, mem_rdata[31:16]} : mem_rdata;

    fetch_hw_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .count     (count),
        .head      (head),
        .next_hw   (next_hw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            skip_low <= 1'b0;
            inst_pc  <= RESET_PC;
            mem_addr <= {RESET_PC[31:2], 2'b00};
        end else if (redirect) begin
            inst_pc  <= {redirect_pc[31:1], 1'b0};
            mem_addr <= {redirect_pc[31:2], 2'b00};
            skip_low <= redirect_pc[1];
            // A request still in flight must be drained and thrown away.
            case (state)
                WAIT:      state <= mem_rvalid ? IDLE : WAIT_DROP;
                WAIT_DROP: state <= mem_rvalid ? IDLE : WAIT_DROP;
                default:   state <= IDLE;
            endcase
        end else begin
            if (xfer)
                inst_pc <= inst_pc + (is_compressed ? 32'd2 : 32'd4);
            case (state)
                IDLE: begin
                    if (mem_req)
                        state <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state    <= IDLE;
                        mem_addr <= mem_addr + 32'd4;
                        skip_low <= 1'b0;
                    end
                end
                WAIT_DROP: begin
                    if (mem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
